// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported req/ack memory between instruction
//                fetch (IF) and the data-access stage (MEM). MEM normally
//                wins, but a streak counter caps consecutive MEM grants while
//                IF waits so fetch is never starved. Fetches flushed by a
//                taken branch/jump still finish on the memory port, but their
//                completion pulse is swallowed.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_STREAK = 4     // 1..15
) (
    input  logic              clk,
    input  logic              reset,

    // Instruction fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,

    // Data access requester
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,

    // Shared memory port
    output logic              mp_req,
    output logic              mp_we,
    output logic [ADDR_W-1:0] mp_addr,
    output logic [DATA_W-1:0] mp_wdata,
    input  logic              mp_ack,
    input  logic [DATA_W-1:0] mp_rdata,

    // Pipeline hold
    output logic              pipe_stall
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] c_streakMax = 4'(MEM_STREAK);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [3:0]          r_streak;      // consecutive MEM grants while IF waited
    logic                r_cancelled;   // current IF transaction was flushed

    logic                r_ifDone;
    logic [DATA_W-1:0]   r_ifRdata;
    logic                r_memDone;
    logic [DATA_W-1:0]   r_memRdata;

    logic                r_mpReq;
    logic                r_mpWe;
    logic [ADDR_W-1:0]   r_mpAddr;
    logic [DATA_W-1:0]   r_mpWdata;

    // ------------------------------------------------------------------------
    // Arbitration decisions (only acted upon in IDLE)
    // ------------------------------------------------------------------------
    logic                w_grantMem;
    logic                w_grantIf;
    logic [3:0]          w_streakNext;

    // MEM wins unless IF has already waited through a full streak of MEM grants.
    assign w_grantMem = mem_req & (~if_req | (r_streak < c_streakMax));

    // A flush in IDLE blocks the fetch grant for that cycle only.
    assign w_grantIf  = ~w_grantMem & if_req & ~if_cancel;

    // Saturating increment; a MEM grant with IF waiting is only possible below
    // the cap, so saturation is a safety net rather than a live path.
    assign w_streakNext = (r_streak >= c_streakMax) ? c_streakMax : (r_streak + 4'd1);

    // ------------------------------------------------------------------------
    // Sequencer: arbitrate in IDLE, hold the memory port until ack, then
    // pulse the matching done for one cycle while in RESP.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_streak    <= 4'd0;
            r_cancelled <= 1'b0;
            r_ifDone    <= 1'b0;
            r_ifRdata   <= '0;
            r_memDone   <= 1'b0;
            r_memRdata  <= '0;
            r_mpReq     <= 1'b0;
            r_mpWe      <= 1'b0;
            r_mpAddr    <= '0;
            r_mpWdata   <= '0;
        end else begin
            // Done outputs are single-cycle pulses by default.
            r_ifDone  <= 1'b0;
            r_memDone <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_grantMem) begin
                        r_state   <= GNT_MEM;
                        r_mpReq   <= 1'b1;
                        r_mpWe    <= mem_we;
                        r_mpAddr  <= mem_addr;
                        r_mpWdata <= mem_wdata;
                        // Only count MEM grants that made IF wait.
                        r_streak  <= if_req ? w_streakNext : 4'd0;
                    end else if (w_grantIf) begin
                        r_state   <= GNT_IF;
                        r_mpReq   <= 1'b1;
                        r_mpWe    <= 1'b0;
                        r_mpAddr  <= if_addr;
                        r_streak  <= 4'd0;
                    end else if (!if_req) begin
                        // IF is not waiting, so there is nothing to be fair to.
                        r_streak  <= 4'd0;
                    end
                end

                GNT_IF: begin
                    // A flush during the grant (including the ack cycle) only
                    // marks the result as stale; the port transaction finishes.
                    if (if_cancel) begin
                        r_cancelled <= 1'b1;
                    end
                    if (mp_ack) begin
                        r_mpReq   <= 1'b0;
                        r_ifRdata <= mp_rdata;
                        r_ifDone  <= ~(r_cancelled | if_cancel);
                        r_state   <= RESP;
                    end
                end

                GNT_MEM: begin
                    if (mp_ack) begin
                        r_mpReq   <= 1'b0;
                        // Stores return nothing meaningful; keep the last load.
                        if (!r_mpWe) begin
                            r_memRdata <= mp_rdata;
                        end
                        r_memDone <= 1'b1;
                        r_state   <= RESP;
                    end
                end

                RESP: begin
                    // Done pulse is visible this cycle; next cycle re-arbitrates.
                    r_cancelled <= 1'b0;
                    r_state     <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign if_done   = r_ifDone;
    assign if_rdata  = r_ifRdata;
    assign mem_done  = r_memDone;
    assign mem_rdata = r_memRdata;
    assign mp_req    = r_mpReq;
    assign mp_we     = r_mpWe;
    assign mp_addr   = r_mpAddr;
    assign mp_wdata  = r_mpWdata;

    // Hold the pipeline while either requester is waiting and has not just
    // been answered; a flushed fetch no longer holds anything up.
    assign pipe_stall = (if_req & ~r_ifDone & ~if_cancel) | (mem_req & ~r_memDone);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A table of per-cycle
//                {stimulus, expected outputs} rows covers fetch, priority,
//                flush, store and reset behaviour; a hand-written sequence
//                checks the MEM streak cap over ten back-to-back grants.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_STREAK = 4;

    logic              clk;
    logic              reset;
    logic              ifReq;
    logic [ADDR_W-1:0] ifAddr;
    logic              ifCancel;
    logic              ifDone;
    logic [DATA_W-1:0] ifRdata;
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              memDone;
    logic [DATA_W-1:0] memRdata;
    logic              mpReq;
    logic              mpWe;
    logic [ADDR_W-1:0] mpAddr;
    logic [DATA_W-1:0] mpWdata;
    logic              mpAck;
    logic [DATA_W-1:0] mpRdata;
    logic              pipeStall;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_STREAK (MEM_STREAK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (ifReq),
        .if_addr    (ifAddr),
        .if_cancel  (ifCancel),
        .if_done    (ifDone),
        .if_rdata   (ifRdata),
        .mem_req    (memReq),
        .mem_we     (memWe),
        .mem_addr   (memAddr),
        .mem_wdata  (memWdata),
        .mem_done   (memDone),
        .mem_rdata  (memRdata),
        .mp_req     (mpReq),
        .mp_we      (mpWe),
        .mp_addr    (mpAddr),
        .mp_wdata   (mpWdata),
        .mp_ack     (mpAck),
        .mp_rdata   (mpRdata),
        .pipe_stall (pipeStall)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        ifCancel;
        logic        memReq;
        logic        memWe;
        logic [31:0] memAddr;
        logic [31:0] memWdata;
        logic        ack;
        logic [31:0] rdata;
        logic        eIfDone;
        logic [31:0] eIfRdata;
        logic        eMemDone;
        logic [31:0] eMemRdata;
        logic        eMpReq;
        logic        eMpWe;
        logic [31:0] eMpAddr;
        logic [31:0] eMpWdata;
        logic        eStall;
    } vec_t;

    vec_t  vecs[$];
    string names[$];
    int    nErr   = 0;
    int    nCheck = 0;

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        nCheck++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic rst,
                       input logic iq, input logic [31:0] ia, input logic ic,
                       input logic mq, input logic mw, input logic [31:0] ma, input logic [31:0] md,
                       input logic ak, input logic [31:0] rd,
                       input logic eid, input logic [31:0] eir, input logic emd, input logic [31:0] emr,
                       input logic epq, input logic epw, input logic [31:0] epa, input logic [31:0] epd,
                       input logic est);
        vec_t v;
        v.rst = rst; v.ifReq = iq; v.ifAddr = ia; v.ifCancel = ic;
        v.memReq = mq; v.memWe = mw; v.memAddr = ma; v.memWdata = md;
        v.ack = ak; v.rdata = rd;
        v.eIfDone = eid; v.eIfRdata = eir; v.eMemDone = emd; v.eMemRdata = emr;
        v.eMpReq = epq; v.eMpWe = epw; v.eMpAddr = epa; v.eMpWdata = epd;
        v.eStall = est;
        vecs.push_back(v);
        names.push_back(nm);
    endtask

    // Bound the whole run
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string order;
        int    grants;
        int    cyc;
        int    ifDones;
        int    memDones;
        int    both;

        reset = 1'b1; ifReq = 0; ifAddr = 0; ifCancel = 0;
        memReq = 0; memWe = 0; memAddr = 0; memWdata = 0;
        mpAck = 0; mpRdata = 0;

        //   name          rst  ifReq ifAddr ifCan  memReq we addr  wdata         ack rdata          ifDone ifRdata      memDone memRdata     mpReq we mpAddr mpWdata      stall
        // 1) fetch, ack in first mp_req cycle
        add("t1_req",      0,   1,'h40,0,   0,0,0,0,               0,0,             0,0,            0,0,            0,0,0,0,              1);
        add("t1_ack",      0,   1,'h40,0,   0,0,0,0,               1,'h8C220004,    0,0,            0,0,            1,0,'h40,0,           1);
        add("t1_done",     0,   1,'h40,0,   0,0,0,0,               0,0,             1,'h8C220004,   0,0,            0,0,'h40,0,           0);
        // 2) simultaneous IF + load, MEM served first, 3-cycle ack
        add("t2_both",     0,   1,'h44,0,   1,0,'h100,0,           0,0,             0,'h8C220004,   0,0,            0,0,'h40,0,           1);
        add("t2_gm1",      0,   1,'h44,0,   1,0,'h100,0,           0,0,             0,'h8C220004,   0,0,            1,0,'h100,0,          1);
        add("t2_gm2",      0,   1,'h44,0,   1,0,'h100,0,           0,0,             0,'h8C220004,   0,0,            1,0,'h100,0,          1);
        add("t2_gm3",      0,   1,'h44,0,   1,0,'h100,0,           1,'h11111111,    0,'h8C220004,   0,0,            1,0,'h100,0,          1);
        add("t2_mdone",    0,   1,'h44,0,   1,0,'h100,0,           0,0,             0,'h8C220004,   1,'h11111111,   0,0,'h100,0,          1);
        add("t2_ifidle",   0,   1,'h44,0,   0,0,0,0,               0,0,             0,'h8C220004,   0,'h11111111,   0,0,'h100,0,          1);
        add("t2_ifgnt",    0,   1,'h44,0,   0,0,0,0,               1,'h22222222,    0,'h8C220004,   0,'h11111111,   1,0,'h44,0,           1);
        add("t2_ifdone",   0,   1,'h44,0,   0,0,0,0,               0,0,             1,'h22222222,   0,'h11111111,   0,0,'h44,0,           0);
        // 4) flush during grant, ack two cycles late; then IDLE flush and ack-cycle flush
        add("t4_req",      0,   1,'h50,0,   0,0,0,0,               0,0,             0,'h22222222,   0,'h11111111,   0,0,'h44,0,           1);
        add("t4_cancel",   0,   1,'h50,1,   0,0,0,0,               0,0,             0,'h22222222,   0,'h11111111,   1,0,'h50,0,           0);
        add("t4_wait",     0,   1,'h60,0,   0,0,0,0,               0,0,             0,'h22222222,   0,'h11111111,   1,0,'h50,0,           1);
        add("t4_ack",      0,   1,'h60,0,   0,0,0,0,               1,'h33333333,    0,'h22222222,   0,'h11111111,   1,0,'h50,0,           1);
        add("t4_nodone",   0,   1,'h60,0,   0,0,0,0,               0,0,             0,'h33333333,   0,'h11111111,   0,0,'h50,0,           1);
        add("t4_regnt",    0,   1,'h60,0,   0,0,0,0,               0,0,             0,'h33333333,   0,'h11111111,   0,0,'h50,0,           1);
        add("t4_gnt60",    0,   1,'h60,0,   0,0,0,0,               1,'h44444444,    0,'h33333333,   0,'h11111111,   1,0,'h60,0,           1);
        add("t4_done60",   0,   1,'h60,0,   0,0,0,0,               0,0,             1,'h44444444,   0,'h11111111,   0,0,'h60,0,           0);
        add("t4_idlecan",  0,   1,'h64,1,   0,0,0,0,               0,0,             0,'h44444444,   0,'h11111111,   0,0,'h60,0,           0);
        add("t4_blocked",  0,   1,'h64,0,   0,0,0,0,               0,0,             0,'h44444444,   0,'h11111111,   0,0,'h60,0,           1);
        add("t4_ackcan",   0,   1,'h64,1,   0,0,0,0,               1,'h55555555,    0,'h44444444,   0,'h11111111,   1,0,'h64,0,           0);
        add("t4_nodone2",  0,   0,0,0,      0,0,0,0,               0,0,             0,'h55555555,   0,'h11111111,   0,0,'h64,0,           0);
        add("t4_idle",     0,   0,0,0,      0,0,0,0,               0,0,             0,'h55555555,   0,'h11111111,   0,0,'h64,0,           0);
        // 5) store: mp_* stable until ack, mem_rdata untouched
        add("t5_req",      0,   0,0,0,      1,1,'h200,'hDEADBEEF,  0,0,             0,'h55555555,   0,'h11111111,   0,0,'h64,0,           1);
        add("t5_gnt",      0,   0,0,0,      1,1,'h200,'hDEADBEEF,  0,0,             0,'h55555555,   0,'h11111111,   1,1,'h200,'hDEADBEEF, 1);
        add("t5_ack",      0,   0,0,0,      1,1,'h200,'hDEADBEEF,  1,'h99999999,    0,'h55555555,   0,'h11111111,   1,1,'h200,'hDEADBEEF, 1);
        add("t5_done",     0,   0,0,0,      1,1,'h200,'hDEADBEEF,  0,0,             0,'h55555555,   1,'h11111111,   0,1,'h200,'hDEADBEEF, 0);
        add("t5_idle",     0,   0,0,0,      0,0,0,0,               0,0,             0,'h55555555,   0,'h11111111,   0,1,'h200,'hDEADBEEF, 0);
        // 6) reset while GNT_MEM waits for ack
        add("t6_req",      0,   0,0,0,      1,0,'h104,0,           0,0,             0,'h55555555,   0,'h11111111,   0,1,'h200,'hDEADBEEF, 1);
        add("t6_rst",      1,   0,0,0,      1,0,'h104,0,           0,0,             0,'h55555555,   0,'h11111111,   1,0,'h104,0,          1);
        add("t6_after",    0,   0,0,0,      0,0,0,0,               0,0,             0,0,            0,0,            0,0,0,0,              0);
        add("t6_strayack", 0,   0,0,0,      0,0,0,0,               1,'h77777777,    0,0,            0,0,            0,0,0,0,              0);
        add("t6_quiet",    0,   0,0,0,      0,0,0,0,               0,0,             0,0,            0,0,            0,0,0,0,              0);

        repeat (2) @(posedge clk);

        // Table: drive just after the edge, compare at the falling edge
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            reset    = vecs[i].rst;
            ifReq    = vecs[i].ifReq;
            ifAddr   = vecs[i].ifAddr;
            ifCancel = vecs[i].ifCancel;
            memReq   = vecs[i].memReq;
            memWe    = vecs[i].memWe;
            memAddr  = vecs[i].memAddr;
            memWdata = vecs[i].memWdata;
            mpAck    = vecs[i].ack;
            mpRdata  = vecs[i].rdata;
            @(negedge clk);
            chk({names[i], ".if_done"},    32'(ifDone),    32'(vecs[i].eIfDone));
            chk({names[i], ".if_rdata"},   ifRdata,        vecs[i].eIfRdata);
            chk({names[i], ".mem_done"},   32'(memDone),   32'(vecs[i].eMemDone));
            chk({names[i], ".mem_rdata"},  memRdata,       vecs[i].eMemRdata);
            chk({names[i], ".mp_req"},     32'(mpReq),     32'(vecs[i].eMpReq));
            chk({names[i], ".mp_we"},      32'(mpWe),      32'(vecs[i].eMpWe));
            chk({names[i], ".mp_addr"},    mpAddr,         vecs[i].eMpAddr);
            chk({names[i], ".mp_wdata"},   mpWdata,        vecs[i].eMpWdata);
            chk({names[i], ".pipe_stall"}, 32'(pipeStall), 32'(vecs[i].eStall));
        end

        // 3) Streak cap: both requesters held; memory acks every grant at once.
        //    Expect four MEM grants, one IF, then four MEM again, one IF.
        @(posedge clk);
        #1;
        reset = 0; mpAck = 0;
        ifReq = 1; ifAddr = 32'h48; ifCancel = 0;
        memReq = 1; memWe = 0; memAddr = 32'h300; memWdata = 0;
        order = ""; grants = 0; cyc = 0; ifDones = 0; memDones = 0; both = 0;
        @(negedge clk);
        while (grants < 10 && cyc < 200) begin
            @(posedge clk);
            #1;
            mpAck   = mpReq;
            mpRdata = 32'hA000_0000 + 32'(grants);
            if (mpReq) begin
                if (mpAddr == 32'h48) order = {order, "I"};
                else                  order = {order, "M"};
                grants++;
            end
            @(negedge clk);
            if (ifDone)  ifDones++;
            if (memDone) memDones++;
            if (ifDone && memDone) both++;
            cyc++;
        end
        // Done cycle of the last grant
        @(posedge clk);
        #1;
        mpAck = 0;
        @(negedge clk);
        if (ifDone)  ifDones++;
        if (memDone) memDones++;
        if (ifDone && memDone) both++;
        chk("t3_if_rdata_last", ifRdata, 32'hA000_0009);
        chk("t3_mem_rdata_last", memRdata, 32'hA000_0008);
        @(posedge clk);
        #1;
        ifReq = 0; memReq = 0;
        @(negedge clk);

        chk("t3_grant_count", 32'(grants), 32'd10);
        nCheck++;
        if (order != "MMMMIMMMMI") begin
            nErr++;
            $display("FAIL t3_grant_order: got %s, expected MMMMIMMMMI", order);
        end
        chk("t3_if_dones", 32'(ifDones), 32'd2);
        chk("t3_mem_dones", 32'(memDones), 32'd8);
        chk("t3_both_done", 32'(both), 32'd0);
        chk("t3_idle_mp_req", 32'(mpReq), 32'd0);

        $display("Result: errors=%0d of %0d checks", nErr, nCheck);
        $finish;
    end

endmodule

`default_nettype wire
